// File: rtl/ysyx_23060077_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package ysyx_23060077_mem_arbiter_pkg;

    localparam int unsigned MemAddrWidth = 32;
    localparam int unsigned MemDataWidth = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIfuRd = 2'd1,
        StLsuRd = 2'd2,
        StLsuWr = 2'd3
    } arb_state_e;

    // Value of the fairness register naming who wins the next IFU/LSU tie.
    localparam logic GrantIfu = 1'b0;
    localparam logic GrantLsu = 1'b1;

    // The LSU should never raise both; if it does, the write goes first.
    function automatic arb_state_e lsu_grant(input logic w_valid);
        return w_valid ? StLsuWr : StLsuRd;
    endfunction

endpackage

// File: rtl/ysyx_23060077_mem_arbiter_if.sv
// Bundle of CPU-side master requests/responses and bridge-side request port.
interface ysyx_23060077_mem_arbiter_if
    import ysyx_23060077_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MemAddrWidth,
    parameter int unsigned DATA_WIDTH = MemDataWidth
) ();

    logic                  ifu_r_valid_i;
    logic [ADDR_WIDTH-1:0] ifu_r_addr_i;
    logic [2:0]            ifu_r_size_i;
    logic [7:0]            ifu_r_len_i;
    logic                  ifu_r_ready_o;
    logic [DATA_WIDTH-1:0] ifu_r_data_o;
    logic                  ifu_r_last_o;

    logic                  lsu_r_valid_i;
    logic [ADDR_WIDTH-1:0] lsu_r_addr_i;
    logic [2:0]            lsu_r_size_i;
    logic [7:0]            lsu_r_len_i;
    logic                  lsu_r_ready_o;
    logic [DATA_WIDTH-1:0] lsu_r_data_o;
    logic                  lsu_r_last_o;

    logic                  lsu_w_valid_i;
    logic [ADDR_WIDTH-1:0] lsu_w_addr_i;
    logic [DATA_WIDTH-1:0] lsu_w_data_i;
    logic [2:0]            lsu_w_size_i;
    logic [7:0]            lsu_w_len_i;
    logic                  lsu_w_ready_o;
    logic                  lsu_w_last_o;

    logic                  mem_r_valid_o;
    logic [ADDR_WIDTH-1:0] mem_r_addr_o;
    logic [2:0]            mem_r_size_o;
    logic [7:0]            mem_r_len_o;
    logic                  mem_r_ready_i;
    logic [DATA_WIDTH-1:0] mem_r_data_i;
    logic                  mem_r_last_i;

    logic                  mem_w_valid_o;
    logic [ADDR_WIDTH-1:0] mem_w_addr_o;
    logic [DATA_WIDTH-1:0] mem_w_data_o;
    logic [2:0]            mem_w_size_o;
    logic [7:0]            mem_w_len_o;
    logic                  mem_w_ready_i;
    logic                  mem_w_last_i;

    // Arbiter view.
    modport slave (
        input  ifu_r_valid_i, ifu_r_addr_i, ifu_r_size_i, ifu_r_len_i,
        output ifu_r_ready_o, ifu_r_data_o, ifu_r_last_o,
        input  lsu_r_valid_i, lsu_r_addr_i, lsu_r_size_i, lsu_r_len_i,
        output lsu_r_ready_o, lsu_r_data_o, lsu_r_last_o,
        input  lsu_w_valid_i, lsu_w_addr_i, lsu_w_data_i, lsu_w_size_i, lsu_w_len_i,
        output lsu_w_ready_o, lsu_w_last_o,
        output mem_r_valid_o, mem_r_addr_o, mem_r_size_o, mem_r_len_o,
        input  mem_r_ready_i, mem_r_data_i, mem_r_last_i,
        output mem_w_valid_o, mem_w_addr_o, mem_w_data_o, mem_w_size_o, mem_w_len_o,
        input  mem_w_ready_i, mem_w_last_i
    );

    // Environment view: CPU masters plus bridge.
    modport master (
        output ifu_r_valid_i, ifu_r_addr_i, ifu_r_size_i, ifu_r_len_i,
        input  ifu_r_ready_o, ifu_r_data_o, ifu_r_last_o,
        output lsu_r_valid_i, lsu_r_addr_i, lsu_r_size_i, lsu_r_len_i,
        input  lsu_r_ready_o, lsu_r_data_o, lsu_r_last_o,
        output lsu_w_valid_i, lsu_w_addr_i, lsu_w_data_i, lsu_w_size_i, lsu_w_len_i,
        input  lsu_w_ready_o, lsu_w_last_o,
        input  mem_r_valid_o, mem_r_addr_o, mem_r_size_o, mem_r_len_o,
        output mem_r_ready_i, mem_r_data_i, mem_r_last_i,
        input  mem_w_valid_o, mem_w_addr_o, mem_w_data_o, mem_w_size_o, mem_w_len_o,
        output mem_w_ready_i, mem_w_last_i
    );

endinterface

// File: rtl/ysyx_23060077_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) arbiter in front of the AXI bridge.
// One transaction at a time; ties go to the master not served last.
module ysyx_23060077_mem_arbiter
    import ysyx_23060077_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MemAddrWidth,
    parameter int unsigned DATA_WIDTH = MemDataWidth
) (
    input logic                      aclk,
    input logic                      areset_n,
    ysyx_23060077_mem_arbiter_if.slave bus
);

    arb_state_e state_q, state_d;
    logic       prio_lsu_q, prio_lsu_d;

    logic ifu_req, lsu_req, r_done;
    assign ifu_req = bus.ifu_r_valid_i;
    assign lsu_req = bus.lsu_r_valid_i | bus.lsu_w_valid_i;
    assign r_done  = bus.mem_r_ready_i & bus.mem_r_last_i;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= StIdle;
            prio_lsu_q <= GrantIfu;
        end else begin
            state_q    <= state_d;
            prio_lsu_q <= prio_lsu_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prio_lsu_d = prio_lsu_q;
        case (state_q)
            StIdle: begin
                if (ifu_req && lsu_req) begin
                    state_d = (prio_lsu_q == GrantLsu) ? lsu_grant(bus.lsu_w_valid_i) : StIfuRd;
                end else if (ifu_req) begin
                    state_d = StIfuRd;
                end else if (lsu_req) begin
                    state_d = lsu_grant(bus.lsu_w_valid_i);
                end
            end
            StIfuRd: begin
                if (r_done) begin
                    state_d    = StIdle;
                    prio_lsu_d = GrantLsu;
                end
            end
            StLsuRd: begin
                if (r_done) begin
                    state_d    = StIdle;
                    prio_lsu_d = GrantIfu;
                end
            end
            StLsuWr: begin
                if (bus.mem_w_last_i) begin
                    state_d    = StIdle;
                    prio_lsu_d = GrantIfu;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [DATA_WIDTH-1:0] w_data, ifu_data, lsu_data;

    // Outputs decode purely from the state register, so reset clears them at once.
    always_comb begin
        bus.mem_r_valid_o = 1'b0;
        r_addr            = '0;
        bus.mem_r_size_o  = '0;
        bus.mem_r_len_o   = '0;
        bus.mem_w_valid_o = 1'b0;
        w_addr            = '0;
        w_data            = '0;
        bus.mem_w_size_o  = '0;
        bus.mem_w_len_o   = '0;
        bus.ifu_r_ready_o = 1'b0;
        bus.ifu_r_last_o  = 1'b0;
        ifu_data          = '0;
        bus.lsu_r_ready_o = 1'b0;
        bus.lsu_r_last_o  = 1'b0;
        lsu_data          = '0;
        bus.lsu_w_ready_o = 1'b0;
        bus.lsu_w_last_o  = 1'b0;
        case (state_q)
            StIfuRd: begin
                bus.mem_r_valid_o = 1'b1;
                r_addr            = bus.ifu_r_addr_i;
                bus.mem_r_size_o  = bus.ifu_r_size_i;
                bus.mem_r_len_o   = bus.ifu_r_len_i;
                bus.ifu_r_ready_o = bus.mem_r_ready_i;
                bus.ifu_r_last_o  = r_done;
                ifu_data          = bus.mem_r_data_i;
            end
            StLsuRd: begin
                bus.mem_r_valid_o = 1'b1;
                r_addr            = bus.lsu_r_addr_i;
                bus.mem_r_size_o  = bus.lsu_r_size_i;
                bus.mem_r_len_o   = bus.lsu_r_len_i;
                bus.lsu_r_ready_o = bus.mem_r_ready_i;
                bus.lsu_r_last_o  = r_done;
                lsu_data          = bus.mem_r_data_i;
            end
            StLsuWr: begin
                bus.mem_w_valid_o = 1'b1;
                w_addr            = bus.lsu_w_addr_i;
                w_data            = bus.lsu_w_data_i;
                bus.mem_w_size_o  = bus.lsu_w_size_i;
                bus.mem_w_len_o   = bus.lsu_w_len_i;
                bus.lsu_w_ready_o = bus.mem_w_ready_i;
                bus.lsu_w_last_o  = bus.mem_w_last_i;
            end
            default: ;
        endcase
    end

    assign bus.mem_r_addr_o = r_addr;
    assign bus.mem_w_addr_o = w_addr;
    assign bus.mem_w_data_o = w_data;
    assign bus.ifu_r_data_o = ifu_data;
    assign bus.lsu_r_data_o = lsu_data;

endmodule

// File: tb/tb_ysyx_23060077_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: per-cycle vector table plus
// hand sequences for bursts and asynchronous reset.
module tb_ysyx_23060077_mem_arbiter;

    localparam logic [31:0] IfuAddr  = 32'h3000_0000;
    localparam logic [31:0] LsuRAddr = 32'h8000_0100;
    localparam logic [31:0] LsuWAddr = 32'h8000_0004;
    localparam logic [31:0] LsuWData = 32'h1234_5678;
    localparam logic [31:0] RdData   = 32'hDEAD_BEEF;

    logic aclk = 1'b0;
    logic areset_n;
    always #5 aclk = ~aclk;

    ysyx_23060077_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ysyx_23060077_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // {mem_r_valid, mem_w_valid, ifu_rdy, ifu_last, lsu_rrdy, lsu_rlast, lsu_wrdy, lsu_wlast}
    logic [7:0]  strobes;
    logic [42:0] r_fields;
    logic [74:0] w_fields;
    logic [63:0] rd_fields;
    assign strobes   = {bus.mem_r_valid_o, bus.mem_w_valid_o, bus.ifu_r_ready_o, bus.ifu_r_last_o,
                        bus.lsu_r_ready_o, bus.lsu_r_last_o, bus.lsu_w_ready_o, bus.lsu_w_last_o};
    assign r_fields  = {bus.mem_r_addr_o, bus.mem_r_size_o, bus.mem_r_len_o};
    assign w_fields  = {bus.mem_w_addr_o, bus.mem_w_data_o, bus.mem_w_size_o, bus.mem_w_len_o};
    assign rd_fields = {bus.ifu_r_data_o, bus.lsu_r_data_o};

    // {ifu_v, lsu_rv, lsu_wv, mem_r_ready, mem_r_last, mem_w_ready, mem_w_last}
    task automatic drive(input logic [6:0] v);
        {bus.ifu_r_valid_i, bus.lsu_r_valid_i, bus.lsu_w_valid_i, bus.mem_r_ready_i,
         bus.mem_r_last_i, bus.mem_w_ready_i, bus.mem_w_last_i} = v;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    typedef struct {
        logic [6:0] in;
        logic [7:0] exp;
        logic [1:0] rsel;   // 0 none, 1 IFU, 2 LSU read granted
        logic       wsel;   // LSU write granted
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    function automatic logic [42:0] exp_r(input logic [1:0] rsel);
        if (rsel == 2'd1) return {IfuAddr, 3'd2, 8'd0};
        if (rsel == 2'd2) return {LsuRAddr, 3'd1, 8'd0};
        return '0;
    endfunction

    int beats, lasts, last_beat, bad;

    initial begin
        areset_n = 1'b0;
        drive(7'b0);
        bus.ifu_r_addr_i = IfuAddr;  bus.ifu_r_size_i = 3'd2; bus.ifu_r_len_i = 8'd0;
        bus.lsu_r_addr_i = LsuRAddr; bus.lsu_r_size_i = 3'd1; bus.lsu_r_len_i = 8'd0;
        bus.lsu_w_addr_i = LsuWAddr; bus.lsu_w_data_i = LsuWData;
        bus.lsu_w_size_i = 3'd2;     bus.lsu_w_len_i  = 8'd0;
        bus.mem_r_data_i = RdData;

        // IFU-only read
        vecs[0]  = '{7'b1000000, 8'b00000000, 2'd0, 1'b0};
        vecs[1]  = '{7'b1000000, 8'b10000000, 2'd1, 1'b0};
        vecs[2]  = '{7'b1001100, 8'b10110000, 2'd1, 1'b0};
        vecs[3]  = '{7'b0000000, 8'b00000000, 2'd0, 1'b0};
        // LSU write
        vecs[4]  = '{7'b0010000, 8'b00000000, 2'd0, 1'b0};
        vecs[5]  = '{7'b0010010, 8'b01000010, 2'd0, 1'b1};
        vecs[6]  = '{7'b0010001, 8'b01000001, 2'd0, 1'b1};
        vecs[7]  = '{7'b0000000, 8'b00000000, 2'd0, 1'b0};
        // IFU and LSU read contend: IFU, LSU, IFU alternation
        vecs[8]  = '{7'b1100000, 8'b00000000, 2'd0, 1'b0};
        vecs[9]  = '{7'b1100000, 8'b10000000, 2'd1, 1'b0};
        vecs[10] = '{7'b1101100, 8'b10110000, 2'd1, 1'b0};
        vecs[11] = '{7'b1100000, 8'b00000000, 2'd0, 1'b0};
        vecs[12] = '{7'b1100000, 8'b10000000, 2'd2, 1'b0};
        vecs[13] = '{7'b1101100, 8'b10001100, 2'd2, 1'b0};
        vecs[14] = '{7'b1100000, 8'b00000000, 2'd0, 1'b0};
        vecs[15] = '{7'b1100000, 8'b10000000, 2'd1, 1'b0};
        vecs[16] = '{7'b1101100, 8'b10110000, 2'd1, 1'b0};
        vecs[17] = '{7'b0100000, 8'b00000000, 2'd0, 1'b0};
        vecs[18] = '{7'b0101100, 8'b10001100, 2'd2, 1'b0};
        vecs[19] = '{7'b0000000, 8'b00000000, 2'd0, 1'b0};
        // Stray bridge strobes in IDLE
        vecs[20] = '{7'b0001111, 8'b00000000, 2'd0, 1'b0};
        vecs[21] = '{7'b0001111, 8'b00000000, 2'd0, 1'b0};
        // LSU raises read and write: write first, stray read strobes ignored
        vecs[22] = '{7'b0110000, 8'b00000000, 2'd0, 1'b0};
        vecs[23] = '{7'b0111101, 8'b01000001, 2'd0, 1'b1};
        vecs[24] = '{7'b0100000, 8'b00000000, 2'd0, 1'b0};
        vecs[25] = '{7'b0101100, 8'b10001100, 2'd2, 1'b0};
        vecs[26] = '{7'b0000000, 8'b00000000, 2'd0, 1'b0};

        repeat (2) @(posedge aclk);
        #1;
        check("reset_strobes", 128'(strobes), 128'(0));
        check("reset_fields", 128'({r_fields, w_fields}), 128'(0));
        @(negedge aclk);
        areset_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].in);
            #1;
            check($sformatf("vec%0d_strobes", i), 128'(strobes), 128'(vecs[i].exp));
            check($sformatf("vec%0d_rmux", i), 128'(r_fields), 128'(exp_r(vecs[i].rsel)));
            check($sformatf("vec%0d_wmux", i), 128'(w_fields),
                  vecs[i].wsel ? 128'({LsuWAddr, LsuWData, 3'd2, 8'd0}) : 128'(0));
            check($sformatf("vec%0d_rdata", i), 128'(rd_fields),
                  128'({(vecs[i].rsel == 2'd1) ? RdData : 32'd0,
                        (vecs[i].rsel == 2'd2) ? RdData : 32'd0}));
            tick();
        end

        // 4-beat IFU burst with an LSU read arriving mid-burst
        bus.ifu_r_len_i = 8'd3;
        drive(7'b1000000);
        tick();
        beats = 0; lasts = 0; last_beat = 0; bad = 0;
        for (int c = 0; c < 6; c++) begin
            bus.lsu_r_valid_i = (c >= 2);
            bus.mem_r_ready_i = (c != 1) && (c != 3);
            bus.mem_r_last_i  = (c == 5);
            #1;
            if (bus.ifu_r_ready_o) beats++;
            if (bus.ifu_r_last_o) begin
                lasts++;
                last_beat = beats;
            end
            if (bus.mem_r_addr_o !== IfuAddr || bus.mem_r_len_o !== 8'd3) bad++;
            tick();
        end
        drive(7'b0100000);
        #1;
        check("burst_ready_pulses", 128'(beats), 128'(4));
        check("burst_last_pulses", 128'(lasts), 128'(1));
        check("burst_last_on_beat4", 128'(last_beat), 128'(4));
        check("burst_held_grant", 128'(bad), 128'(0));
        check("burst_idle_gap", 128'(strobes), 128'(0));
        tick();
        check("post_burst_lsu_grant", 128'({bus.mem_r_valid_o, bus.mem_r_addr_o}),
              128'({1'b1, LsuRAddr}));
        drive(7'b0101100);
        #1;
        check("post_burst_lsu_last", 128'(strobes), 128'(8'b10001100));
        tick();
        bus.ifu_r_len_i = 8'd0;

        // IFU read so the fairness pointer favours the LSU before reset
        drive(7'b1000000);
        tick();
        drive(7'b1001100);
        tick();

        // Reset in the middle of an LSU write
        drive(7'b0010010);
        tick();
        check("wr_before_reset", 128'(strobes), 128'(8'b01000010));
        #2;
        areset_n = 1'b0;
        #1;
        check("async_reset_strobes", 128'(strobes), 128'(0));
        check("async_reset_fields", 128'({r_fields, w_fields, rd_fields}), 128'(0));
        drive(7'b0);
        @(negedge aclk);
        areset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("post_reset_idle%0d", c), 128'(strobes), 128'(0));
        end
        // Fairness pointer must be back to IFU-first
        drive(7'b1100000);
        tick();
        check("post_reset_prio_ifu", 128'({bus.mem_r_valid_o, bus.mem_r_addr_o}),
              128'({1'b1, IfuAddr}));
        drive(7'b1101100);
        #1;
        check("post_reset_ifu_last", 128'(strobes), 128'(8'b10110000));
        tick();
        drive(7'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
